// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter: size codes, grant IDs, FSM states.
// The optional misalignment check is enabled by defining MEM_ALIGN_CHECK_EN.
package mem_port_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_ACK    = 3'd5
    } state_e;

    // Half needs addr[0]=0, word needs addr[1:0]=0; size 11 behaves as word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: sub-word store merge and load extract/extend,
// little-endian lanes (byte0 = bits[7:0]).
module mem_lane_unit
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  byte_sh_s;
    logic [4:0]  half_sh_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] mask_s;
    logic [31:0] ins_s;

    assign byte_sh_s = {lane, 3'b000};
    assign half_sh_s = {lane[1], 4'b0000};

    // Load extraction and extension from the word currently on the read bus
    always_comb begin
        byte_s    = 8'(rd_word >> byte_sh_s);
        half_s    = 16'(rd_word >> half_sh_s);
        load_data = rd_word;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
            SZ_HALF: load_data = {{16{sign_ext & half_s[15]}}, half_s};
            default: load_data = rd_word;
        endcase
    end

    // Store merge of the right-justified store data into the captured old word
    always_comb begin
        mask_s = 32'h0000_0000;
        ins_s  = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                mask_s = 32'h0000_00FF << byte_sh_s;
                ins_s  = {24'h00_0000, wdata[7:0]} << byte_sh_s;
            end
            SZ_HALF: begin
                mask_s = 32'h0000_FFFF << half_sh_s;
                ins_s  = {16'h0000, wdata[15:0]} << half_sh_s;
            end
            default: begin
                mask_s = 32'hFFFF_FFFF;
                ins_s  = wdata;
            end
        endcase
        merged = (old_word & ~mask_s) | (ins_s & mask_s);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between CPU data port and debug loader for a single-port data RAM,
// with read-modify-write for sub-word stores. Define MEM_ALIGN_CHECK_EN to fault misaligned CPU accesses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [1:0]        c_size,
    input  logic              c_signed,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_ack,
    output logic [31:0]       c_rdata,
    output logic              c_err,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [31:0]       g_wdata,
    output logic              g_ack,
    output logic [31:0]       g_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       old_q, old_d;
    logic              c_ack_q, c_ack_d;
    logic              c_err_q, c_err_d;
    logic [31:0]       c_rdata_q, c_rdata_d;
    logic              g_ack_q, g_ack_d;
    logic [31:0]       g_rdata_q, g_rdata_d;

    logic              gnt_s;
    logic              misal_s;
    logic              in_we_s;
    logic [1:0]        in_size_s;
    logic [31:0]       load_s;
    logic [31:0]       merged_s;

    // Grant choice: under contention the port that did not win last time goes next
    always_comb begin
        if (c_req && g_req) begin
            gnt_s = ~gnt_q;
        end else if (g_req) begin
            gnt_s = GNT_DBG;
        end else begin
            gnt_s = GNT_CPU;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misal_s = (gnt_s == GNT_CPU) && is_misaligned(c_size, c_addr[1:0]);
`else
    assign misal_s = 1'b0;
`endif

    assign in_we_s   = (gnt_s == GNT_DBG) ? g_we : c_we;
    assign in_size_s = (gnt_s == GNT_DBG) ? SZ_WORD : c_size;

    mem_lane_unit u_lane (
        .size      (size_q),
        .sign_ext  (sgn_q),
        .lane      (addr_q[1:0]),
        .rd_word   (ram_rdata),
        .old_word  (old_q),
        .wdata     (wdata_q),
        .load_data (load_s),
        .merged    (merged_s)
    );

    // Next-state, latch and registered-output computation
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        old_d     = old_q;
        c_ack_d   = 1'b0;
        c_err_d   = 1'b0;
        c_rdata_d = c_rdata_q;
        g_ack_d   = 1'b0;
        g_rdata_d = g_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (c_req || g_req) begin
                    gnt_d  = gnt_s;
                    we_d   = in_we_s;
                    size_d = in_size_s;
                    if (gnt_s == GNT_DBG) begin
                        sgn_d   = 1'b0;
                        addr_d  = g_addr;
                        wdata_d = g_wdata;
                    end else begin
                        sgn_d   = c_signed;
                        addr_d  = c_addr;
                        wdata_d = c_wdata;
                    end
                    if (misal_s) begin
                        state_d   = ST_ACK;
                        c_ack_d   = 1'b1;
                        c_err_d   = 1'b1;
                        c_rdata_d = 32'h0000_0000;
                    end else if (!in_we_s) begin
                        state_d = ST_RD;
                    end else if ((in_size_s == SZ_BYTE) || (in_size_s == SZ_HALF)) begin
                        state_d = ST_RMW_RD;
                    end else begin
                        state_d = ST_WR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                state_d = ST_ACK;
                if (gnt_q == GNT_DBG) begin
                    g_ack_d   = 1'b1;
                    g_rdata_d = ram_rdata;
                end else begin
                    c_ack_d   = 1'b1;
                    c_rdata_d = load_s;
                end
            end
            ST_RMW_RD: begin
                state_d = ST_RMW_WR;
                old_d   = ram_rdata;
            end
            ST_WR, ST_RMW_WR: begin
                state_d = ST_ACK;
                if (gnt_q == GNT_DBG) begin
                    g_ack_d = 1'b1;
                end else begin
                    c_ack_d = 1'b1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= GNT_CPU;
            we_q      <= 1'b0;
            size_q    <= SZ_WORD;
            sgn_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0000_0000;
            old_q     <= 32'h0000_0000;
            c_ack_q   <= 1'b0;
            c_err_q   <= 1'b0;
            c_rdata_q <= 32'h0000_0000;
            g_ack_q   <= 1'b0;
            g_rdata_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            size_q    <= size_d;
            sgn_q     <= sgn_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            old_q     <= old_d;
            c_ack_q   <= c_ack_d;
            c_err_q   <= c_err_d;
            c_rdata_q <= c_rdata_d;
            g_ack_q   <= g_ack_d;
            g_rdata_q <= g_rdata_d;
        end
    end

    // RAM side is decoded from state so a reset drops the write enable at once
    always_comb begin
        ram_addr = {addr_q[ADDR_W-1:2], 2'b00};
        ram_we   = (state_q == ST_WR) || (state_q == ST_RMW_WR);
        if (state_q == ST_WR) begin
            ram_wdata = wdata_q;
        end else if (state_q == ST_RMW_WR) begin
            ram_wdata = merged_s;
        end else begin
            ram_wdata = 32'h0000_0000;
        end
    end

    assign c_ack   = c_ack_q;
    assign c_err   = c_err_q;
    assign c_rdata = c_rdata_q;
    assign g_ack   = g_ack_q;
    assign g_rdata = g_rdata_q;

    logic unused_s;
    assign unused_s = we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural 2048x32 RAM.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, c_signed;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        c_ack, c_err;
    logic        g_req, g_we;
    logic [31:0] g_addr, g_wdata, g_rdata;
    logic        g_ack;
    logic        ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic [31:0] mem [0:2047];
    int          we_cnt = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          fail_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_signed(c_signed),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_ack(g_ack), .g_rdata(g_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    assign ram_rdata = mem[ram_addr[12:2]];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[12:2]] <= ram_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // lat = cycles from the sampling edge to the visible ack (1 = right after it)
    task automatic cpu_op(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int wes);
        int we0;
        we0 = we_cnt;
        c_req = 1'b1; c_we = we; c_size = size; c_signed = sgn; c_addr = addr; c_wdata = wdata;
        @(posedge clk); #1;
        lat = 1;
        while (!c_ack && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = c_rdata; err = c_err; wes = we_cnt - we0;
        c_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic dbg_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
        g_req = 1'b1; g_we = we; g_addr = addr; g_wdata = wdata;
        @(posedge clk); #1;
        lat = 1;
        while (!g_ack && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = g_rdata;
        g_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat, wes, n;
        logic [31:0] order [0:3];

        for (int i = 0; i < 2048; i++) mem[i] = 32'h0000_0000;
        rst_n = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_size = 2'b00; c_signed = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
        g_req = 1'b0; g_we = 1'b0; g_addr = 32'h0; g_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c_ack", {31'h0, c_ack}, 32'h0);
        chk("rst_g_ack", {31'h0, g_ack}, 32'h0);
        chk("rst_c_err", {31'h0, c_err}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst_c_rdata", c_rdata, 32'h0);
        chk("rst_g_rdata", g_rdata, 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // word store then word load
        cpu_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, err, lat, wes);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_wes", 32'(wes), 32'd1);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        cpu_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, lat, wes);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_wes", 32'(wes), 32'd0);
        chk("lw_err", {31'h0, err}, 32'h0);

        // byte store via read-modify-write
        cpu_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, err, lat, wes);
        cpu_op(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, rd, err, lat, wes);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_wes", 32'(wes), 32'd1);
        chk("sb_mem", mem[8], 32'h1122AA44);

        // sub-word loads
        cpu_op(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, err, lat, wes);
        chk("lb_s", rd, 32'hFFFFFFAA);
        cpu_op(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd, err, lat, wes);
        chk("lbu", rd, 32'h000000AA);
        cpu_op(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, err, lat, wes);
        chk("lh_s_hi", rd, 32'h00001122);
        cpu_op(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd, err, lat, wes);
        chk("lh_s_lo", rd, 32'hFFFFAA44);
        cpu_op(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, rd, err, lat, wes);
        chk("lhu_lo", rd, 32'h0000AA44);
        cpu_op(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, rd, err, lat, wes);
        chk("lb_s_pos", rd, 32'h00000044);

        // half store into upper lane
        cpu_op(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, rd, err, lat, wes);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_mem", mem[8], 32'hBEEFAA44);

        // debug port write/read, low address bits ignored
        dbg_op(1'b1, 32'h40, 32'hCAFEF00D, rd, lat);
        chk("gw_lat", 32'(lat), 32'd2);
        chk("gw_mem", mem[16], 32'hCAFEF00D);
        dbg_op(1'b0, 32'h43, 32'h0, rd, lat);
        chk("gr_lat", 32'(lat), 32'd2);
        chk("gr_data", rd, 32'hCAFEF00D);

        // misaligned word load
        cpu_op(1'b0, 2'b10, 1'b0, 32'h23, 32'h0, rd, err, lat, wes);
        chk("mis_wes", 32'(wes), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_err", {31'h0, err}, 32'h1);
        chk("mis_data", rd, 32'h0);
`else
        chk("mis_lat", 32'(lat), 32'd2);
        chk("mis_err", {31'h0, err}, 32'h0);
        chk("mis_data", rd, 32'hBEEFAA44);
`endif
        // size 11 behaves as a word
        cpu_op(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, rd, err, lat, wes);
        chk("sz11_data", rd, 32'hDEADBEEF);

        // contention from reset: DBG first, then alternating
        rst_n = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_size = 2'b10; c_signed = 1'b0; c_addr = 32'h10;
        g_req = 1'b1; g_we = 1'b0; g_addr = 32'h40;
        for (int i = 0; i < 4; i++) order[i] = 32'd2;
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(posedge clk); #1;
            if (g_ack) begin
                order[n] = 32'd1;
                n++;
                chk("cont_g_data", g_rdata, 32'hCAFEF00D);
            end else if (c_ack) begin
                order[n] = 32'd0;
                n++;
                chk("cont_c_data", c_rdata, 32'hDEADBEEF);
            end
        end
        chk("cont_0", order[0], 32'd1);
        chk("cont_1", order[1], 32'd0);
        chk("cont_2", order[2], 32'd1);
        chk("cont_3", order[3], 32'd0);
        c_req = 1'b0; g_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset during RMW_RD aborts without touching the RAM
        c_req = 1'b1; c_we = 1'b1; c_size = 2'b00; c_addr = 32'h21; c_wdata = 32'h77;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ram_we", {31'h0, ram_we}, 32'h0);
        chk("abort_c_ack", {31'h0, c_ack}, 32'h0);
        chk("abort_g_ack", {31'h0, g_ack}, 32'h0);
        c_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_mem", mem[8], 32'hBEEFAA44);
        c_req = 1'b1; c_we = 1'b0; c_size = 2'b10; c_addr = 32'h10;
        g_req = 1'b1; g_we = 1'b0; g_addr = 32'h40;
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 10 && n == 0; cyc++) begin
            @(posedge clk); #1;
            if (g_ack) begin
                n = 1;
            end else if (c_ack) begin
                n = 2;
            end
        end
        chk("post_rst_first", 32'(n), 32'd1);
        c_req = 1'b0; g_req = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
